// File: rtl/shadow_dump_arbiter.sv
// Shadow-capture dump arbiter.
// Broadcasts capture enable until frozen, then walks the chains one at a time,
// assembling their serial dump bits (LSB first) into words handed downstream
// over a valid/ready handshake. Outputs are registered.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_CAPT   | chains capturing, c_en high, waiting for trig
// S_FROZEN | capture stopped, waiting for dump_req
// S_SHIFT  | dump_en[idx] high, collecting bits of chain idx
// S_HOLD   | word presented, waiting for word_rdy
// S_DONE   | one-cycle done pulse, then back to capture

module shadow_dump_arbiter #(
  parameter int N_CHAINS = 4,
  parameter int WORD_W   = 32,
  parameter int ID_W     = 2
) (
  input  logic                sh_clk,
  input  logic                sh_rst,
  input  logic                trig,
  input  logic                dump_req,
  input  logic [N_CHAINS-1:0] ch_out,
  input  logic [N_CHAINS-1:0] ch_out_vld,
  input  logic [N_CHAINS-1:0] ch_out_done,
  input  logic                word_rdy,
  output logic                c_en,
  output logic [N_CHAINS-1:0] dump_en,
  output logic [WORD_W-1:0]   word_out,
  output logic                word_vld,
  output logic [ID_W-1:0]     word_id,
  output logic                word_last,
  output logic                busy,
  output logic                done
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [ID_W-1:0]   IDX_LAST = ID_W'(N_CHAINS - 1);
  localparam logic [N_CHAINS-1:0] ONE    = N_CHAINS'(1);

  typedef enum logic [2:0] {
    S_CAPT,
    S_FROZEN,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_word;
  logic                r_c_en;
  logic [N_CHAINS-1:0] r_dump_en;
  logic                r_word_vld;
  logic [ID_W-1:0]     r_word_id;
  logic                r_word_last;
  logic                r_busy;
  logic                r_done;

  logic                w_bit;
  logic                w_vld;
  logic                w_chain_done;
  logic                w_word_full;
  logic                w_has_bits;
  logic [ID_W-1:0]     w_idx_inc;
  logic [WORD_W-1:0]   w_word_nxt;

  // Only the selected chain is looked at; everything else is ignored.
  assign w_bit        = ch_out[r_idx];
  assign w_vld        = ch_out_vld[r_idx];
  assign w_chain_done = ch_out_done[r_idx];
  assign w_word_full  = w_vld && (r_cnt == CNT_LAST);
  // A same-cycle valid bit counts before done is judged.
  assign w_has_bits   = w_vld || (r_cnt != '0);
  assign w_idx_inc    = r_idx + ID_W'(1);

  // Merge the incoming bit into the word under assembly.
  always_comb begin
    w_word_nxt = r_word;
    if (w_vld) begin
      w_word_nxt[r_cnt] = w_bit;
    end
  end

  // Sequencer: state, chain index, bit count, word and registered outputs.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_state     <= S_CAPT;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_word      <= '0;
      r_c_en      <= 1'b1;
      r_dump_en   <= '0;
      r_word_vld  <= 1'b0;
      r_word_id   <= '0;
      r_word_last <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CAPT: begin
          if (trig) begin
            r_state <= S_FROZEN;
            r_c_en  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_FROZEN: begin
          if (dump_req) begin
            r_state   <= S_SHIFT;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_dump_en <= ONE;
          end
        end
        S_SHIFT: begin
          r_word <= w_word_nxt;
          if (w_word_full || (w_chain_done && w_has_bits)) begin
            // Unfilled MSBs are already zero: the word is cleared on each handoff.
            r_state     <= S_HOLD;
            r_dump_en   <= '0;
            r_word_vld  <= 1'b1;
            r_word_id   <= r_idx;
            r_word_last <= w_chain_done;
          end else if (w_chain_done) begin
            // Chain ended on a word boundary: nothing left to emit.
            if (r_idx == IDX_LAST) begin
              r_state   <= S_DONE;
              r_dump_en <= '0;
              r_done    <= 1'b1;
            end else begin
              r_idx     <= w_idx_inc;
              r_dump_en <= ONE << w_idx_inc;
            end
          end else if (w_vld) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (word_rdy) begin
            r_word_vld  <= 1'b0;
            r_word_last <= 1'b0;
            r_cnt       <= '0;
            r_word      <= '0;
            if (!r_word_last) begin
              r_state   <= S_SHIFT;
              r_dump_en <= ONE << r_idx;
            end else if (r_idx == IDX_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_SHIFT;
              r_idx     <= w_idx_inc;
              r_dump_en <= ONE << w_idx_inc;
            end
          end
        end
        S_DONE: begin
          r_state <= S_CAPT;
          r_c_en  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_CAPT;
          r_c_en    <= 1'b1;
          r_dump_en <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign c_en      = r_c_en;
  assign dump_en   = r_dump_en;
  assign word_out  = r_word;
  assign word_vld  = r_word_vld;
  assign word_id   = r_word_id;
  assign word_last = r_word_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_shadow_dump_arbiter.sv
// Directed bench for shadow_dump_arbiter: a behavioural chain model answers
// dump_en, a collector records handed-off words, expectations are hand-computed.

module tb_shadow_dump_arbiter;

  logic        sh_clk;
  logic        sh_rst;
  logic        trig;
  logic        dump_req;
  logic [3:0]  ch_out;
  logic [3:0]  ch_out_vld;
  logic [3:0]  ch_out_done;
  logic        word_rdy;
  logic        c_en;
  logic [3:0]  dump_en;
  logic [31:0] word_out;
  logic        word_vld;
  logic [1:0]  word_id;
  logic        word_last;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  shadow_dump_arbiter #(.N_CHAINS(4), .WORD_W(32), .ID_W(2)) dut (
    .sh_clk      (sh_clk),
    .sh_rst      (sh_rst),
    .trig        (trig),
    .dump_req    (dump_req),
    .ch_out      (ch_out),
    .ch_out_vld  (ch_out_vld),
    .ch_out_done (ch_out_done),
    .word_rdy    (word_rdy),
    .c_en        (c_en),
    .dump_en     (dump_en),
    .word_out    (word_out),
    .word_vld    (word_vld),
    .word_id     (word_id),
    .word_last   (word_last),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    sh_clk = 1'b0;
    forever #5 sh_clk = ~sh_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- chain model ----------------
  logic [127:0] cdata [4];
  int           clen  [4];
  bit           cwl   [4];
  int           cpos  [4];
  bit           cacc  [4];
  bit           spur;

  initial begin
    ch_out = '0; ch_out_vld = '0; ch_out_done = '0;
    spur = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cdata[c] = '0; clen[c] = 0; cwl[c] = 1'b0; cpos[c] = 0; cacc[c] = 1'b0;
    end
    forever begin
      logic [3:0] b, v, d;
      @(negedge sh_clk);
      b = '0; v = '0; d = '0;
      for (int c = 0; c < 4; c++) begin
        if (cacc[c]) cpos[c]++;
        if (dump_en[c]) begin
          if (cpos[c] < clen[c]) begin
            b[c] = cdata[c][cpos[c]];
            v[c] = 1'b1;
            d[c] = cwl[c] && (cpos[c] == clen[c] - 1);
          end else begin
            d[c] = 1'b1;
          end
        end else if (c == 3 && spur && dump_en[0]) begin
          b[c] = 1'b1; v[c] = 1'b1; d[c] = 1'b1;
        end
        cacc[c] = v[c] && dump_en[c] && !sh_rst;
      end
      ch_out = b; ch_out_vld = v; ch_out_done = d;
    end
  end

  // ---------------- collector ----------------
  typedef struct {
    logic [31:0] w;
    logic [1:0]  id;
    logic        last;
  } wrec_t;
  wrec_t q[$];
  int    done_cnt;

  initial begin
    done_cnt = 0;
    forever begin
      wrec_t r;
      @(negedge sh_clk);
      if (word_vld && word_rdy && !sh_rst) begin
        r.w = word_out; r.id = word_id; r.last = word_last;
        q.push_back(r);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge sh_clk);
    #1;
  endtask

  task automatic cfg(input int c, input logic [127:0] data, input int len, input bit wl);
    cdata[c] = data; clen[c] = len; cwl[c] = wl; cpos[c] = 0; cacc[c] = 1'b0;
  endtask

  task automatic start_dump();
    q.delete();
    done_cnt = 0;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    dump_req = 1'b1; tick(); dump_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic chk_word(input string tag, input int i, input logic [31:0] w,
                          input logic [1:0] id, input logic last);
    if (i < q.size()) begin
      chk({tag, "_data"}, 64'(q[i].w), 64'(w));
      chk({tag, "_id"},   64'(q[i].id), 64'(id));
      chk({tag, "_last"}, 64'(q[i].last), 64'(last));
    end else begin
      chk({tag, "_present"}, 64'(q.size()), 64'(i + 1));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_c_en"},      64'(c_en), 64'd1);
    chk({tag, "_dump_en"},   64'(dump_en), 64'd0);
    chk({tag, "_word_vld"},  64'(word_vld), 64'd0);
    chk({tag, "_word_id"},   64'(word_id), 64'd0);
    chk({tag, "_word_last"}, 64'(word_last), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_word_out"},  64'(word_out), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    sh_rst = 1'b1; trig = 1'b0; dump_req = 1'b0; word_rdy = 1'b1;
    tick(); tick(); tick();
    chk_reset_outs("rst");
    sh_rst = 1'b0;

    // dump_req in CAPT is ignored
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    chk("capt_dumpreq_ign_busy", 64'(busy), 64'd0);
    chk("capt_dumpreq_ign_en",   64'(dump_en), 64'd0);
    tick(); tick();

    // trig freezes capture on the next cycle; dump_req starts chain 0
    cfg(0, 128'h2A_DEADBEEF, 38, 1'b1);
    cfg(1, '0, 0, 1'b1); cfg(2, '0, 0, 1'b1); cfg(3, '0, 0, 1'b1);
    q.delete(); done_cnt = 0;
    chk("pre_trig_c_en", 64'(c_en), 64'd1);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("trig_c_en", 64'(c_en), 64'd0);
    chk("trig_busy", 64'(busy), 64'd1);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("frozen_trig_ign_en", 64'(dump_en), 64'd0);
    tick(); tick();
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    chk("dumpreq_en0", 64'(dump_en), 64'b0001);
    wait_done("t39");
    chk("t39_nwords", 64'(q.size()), 64'd2);
    chk_word("t39_w0", 0, 32'hDEADBEEF, 2'd0, 1'b0);
    chk_word("t39_w1", 1, 32'h0000002A, 2'd0, 1'b1);
    tick();
    chk("t39_c_en_after", 64'(c_en), 64'd1);
    chk("t39_busy_after", 64'(busy), 64'd0);
    chk("t39_done_once",  64'(done_cnt), 64'd1);

    // same chain with a 7-cycle downstream stall on the first word
    cfg(0, 128'h2A_DEADBEEF, 38, 1'b1);
    cfg(1, '0, 0, 1'b1); cfg(2, '0, 0, 1'b1); cfg(3, '0, 0, 1'b1);
    word_rdy = 1'b0;
    start_dump();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (word_vld) seen = 1'b1; else tick();
    end
    chk("t40_vld_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 7; i++) begin
      chk("t40_stall_hold", {27'd0, dump_en, word_vld, word_out}, {27'd0, 4'b0000, 1'b1, 32'hDEADBEEF});
      tick();
    end
    word_rdy = 1'b1;
    wait_done("t40");
    chk("t40_nwords", 64'(q.size()), 64'd2);
    chk_word("t40_w0", 0, 32'hDEADBEEF, 2'd0, 1'b0);
    chk_word("t40_w1", 1, 32'h0000002A, 2'd0, 1'b1);
    tick(); tick();

    // all four chains exactly one word, done on the final bit
    cfg(0, 128'h11112222, 32, 1'b1);
    cfg(1, 128'h33334444, 32, 1'b1);
    cfg(2, 128'h55556666, 32, 1'b1);
    cfg(3, 128'h77778888, 32, 1'b1);
    start_dump();
    wait_done("t41");
    tick();
    chk("t41_c_en_after", 64'(c_en), 64'd1);
    chk("t41_nwords", 64'(q.size()), 64'd4);
    chk_word("t41_w0", 0, 32'h11112222, 2'd0, 1'b1);
    chk_word("t41_w1", 1, 32'h33334444, 2'd1, 1'b1);
    chk_word("t41_w2", 2, 32'h55556666, 2'd2, 1'b1);
    chk_word("t41_w3", 3, 32'h77778888, 2'd3, 1'b1);
    tick(); tick();
    chk("t41_done_once", 64'(done_cnt), 64'd1);

    // reset in the middle of chain 2
    cfg(0, 128'hAAAA0000, 32, 1'b1);
    cfg(1, 128'hBBBB1111, 32, 1'b1);
    cfg(2, 128'hFF_CCCC2222, 40, 1'b1);
    cfg(3, 128'hDDDD3333, 32, 1'b1);
    start_dump();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (dump_en == 4'b0100) seen = 1'b1; else tick();
    end
    chk("t42_chain2_reached", 64'(seen), 64'd1);
    tick(); tick(); tick();
    sh_rst = 1'b1; tick(); sh_rst = 1'b0;
    chk_reset_outs("t42_rst");
    tick();
    cfg(0, 128'h0F0F0F0F, 32, 1'b1);
    cfg(1, 128'h1E1E1E1E, 32, 1'b1);
    cfg(2, 128'h2D2D2D2D, 32, 1'b1);
    cfg(3, 128'h3C3C3C3C, 32, 1'b1);
    start_dump();
    wait_done("t42");
    chk("t42_nwords", 64'(q.size()), 64'd4);
    chk_word("t42_w0", 0, 32'h0F0F0F0F, 2'd0, 1'b1);
    chk_word("t42_w2", 2, 32'h2D2D2D2D, 2'd2, 1'b1);
    tick(); tick();

    // empty chain 1, spurious chain-3 traffic during chain 0,
    // chain 2 ends on a word boundary with a separate done,
    // chain 3 is exactly two words with done on the final bit
    cfg(0, 128'hCAFEF00D, 32, 1'b1);
    cfg(1, '0, 0, 1'b1);
    cfg(2, 128'h13579BDF, 32, 1'b0);
    cfg(3, 128'h01234567_89ABCDEF, 64, 1'b1);
    spur = 1'b1;
    start_dump();
    wait_done("t43");
    spur = 1'b0;
    chk("t43_nwords", 64'(q.size()), 64'd4);
    chk_word("t43_w0", 0, 32'hCAFEF00D, 2'd0, 1'b1);
    chk_word("t43_w1", 1, 32'h13579BDF, 2'd2, 1'b0);
    chk_word("t43_w2", 2, 32'h89ABCDEF, 2'd3, 1'b0);
    chk_word("t43_w3", 3, 32'h01234567, 2'd3, 1'b1);
    tick(); tick();
    chk("t43_done_once", 64'(done_cnt), 64'd1);
    chk("t43_c_en_after", 64'(c_en), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // dump_en must never select two chains at once
  initial begin
    forever begin
      @(negedge sh_clk);
      if ($countones(dump_en) > 1) chk("dump_en_onehot", 64'($countones(dump_en)), 64'd1);
    end
  end

endmodule

// File: doc/shadow_dump_arbiter.md
SHADOW_DUMP_ARBITER -- requirements
Module: shadow_dump_arbiter

Interface
REQ-001 Parameter N_CHAINS, default 4, number of shadow-capture chains served (2..16).
REQ-002 Parameter WORD_W, default 32, width of the assembled dump word (8..64).
REQ-003 Parameter ID_W, default 2, width of the chain index, with ID_W >= clog2(N_CHAINS).
REQ-004 sh_clk  in  1  shadow/data clock; the block's only clock; all state updates on its rising edge.
REQ-005 sh_rst  in  1  reset, synchronous, active-high.
REQ-006 trig  in  1  freeze request; stops capture.
REQ-007 dump_req  in  1  start-dump request.
REQ-008 ch_out  in  N_CHAINS  serial dump data, one bit per chain.
REQ-009 ch_out_vld  in  N_CHAINS  ch_out bit valid, per chain.
REQ-010 ch_out_done  in  N_CHAINS  chain fully dumped, per chain.
REQ-011 word_rdy  in  1  downstream accepts word.
REQ-012 c_en  out  1  capture enable broadcast to all chains.
REQ-013 dump_en  out  N_CHAINS  one-hot-or-zero dump enable, per chain.
REQ-014 word_out  out  WORD_W  assembled dump word.
REQ-015 word_vld  out  1  word_out valid.
REQ-016 word_id  out  ID_W  chain index of word_out.
REQ-017 word_last  out  1  word_out is the final word of its chain.
REQ-018 busy  out  1  high in every state other than CAPT.
REQ-019 done  out  1  one-cycle pulse when the full dump completes.

Function
REQ-020 FSM states: CAPT, FROZEN, SHIFT, HOLD, DONE; all outputs registered.
REQ-021 CAPT: c_en=1; trig moves to FROZEN; c_en=0 from the next cycle; dump_req ignored.
REQ-022 FROZEN: c_en=0; dump_req moves to SHIFT with idx=0, bit count cnt=0; dump_en[0]=1 the next cycle; trig ignored.
REQ-023 SHIFT: dump_en[idx]=1 only; each cycle ch_out_vld[idx]=1, ch_out[idx] is written into word bit cnt (LSB first) and cnt increments.
REQ-024 SHIFT: when a bit is accepted with cnt=WORD_W-1 -> HOLD, word_vld=1 and dump_en=0 the next cycle; word_last=0.
REQ-025 SHIFT: ch_out_done[idx]=1 (a same-cycle vld bit is accepted first) with cnt>0 after that bit -> HOLD with the remaining MSBs zero-padded, word_last=1.
REQ-026 SHIFT: ch_out_done[idx]=1 with cnt=0 after acceptance -> advance the chain with no word emitted; the previous emitted word's word_last is not revised.
REQ-027 Chain exactly WORD_W-multiple long: the bit completing a word while ch_out_done[idx]=1 gives word_last=1.
REQ-028 HOLD: word_out, word_id=idx and word_last are stable while word_vld=1 and word_rdy=0.
REQ-029 HOLD: on word_vld & word_rdy, word_vld=0 the next cycle and cnt=0.
REQ-030 HOLD exit: if word_last=0, return to SHIFT on the same idx.
REQ-031 HOLD exit: if word_last=1 and idx<N_CHAINS-1, idx+1 and SHIFT; dump_en[idx+1]=1 the next cycle.
REQ-032 HOLD exit: if word_last=1 and idx=N_CHAINS-1, go to DONE.
REQ-033 DONE: done=1 for one cycle, then CAPT with c_en=1.
REQ-034 Inputs from non-selected chains ignored; trig and dump_req ignored outside their accepting states.
REQ-035 dump_en never high in two chains simultaneously nor in CAPT/FROZEN/HOLD/DONE.

Reset
REQ-036 sh_rst=1 at any edge, including mid-SHIFT or HOLD, forces state CAPT, idx=0, cnt=0, word_out=0 from the next cycle.
REQ-037 Output reset values: c_en=1, dump_en=0, word_vld=0, word_id=0, word_last=0, busy=0, done=0; no word in flight survives reset.

Verification
REQ-038 Reset then trig at cycle 5 -> c_en=0 at cycle 6, busy=1; dump_req at 10 -> dump_en=4'b0001 at 11.
REQ-039 Chain 0 shifts 38 bits 0x2A_DEADBEEF, done on bit 38, word_rdy=1 -> words 0xDEADBEEF (last=0), 0x0000002A (last=1), id=0.
REQ-040 Same as REQ-039 with word_rdy held 0 for 7 cycles -> word_out stable, dump_en=0 throughout, no bit lost.
REQ-041 All 4 chains 32 bits each, done with final bit -> exactly 4 words, last=1, ids 0..3, single done pulse, then c_en=1.
REQ-042 sh_rst mid-chain 2 SHIFT -> next cycle all outputs at reset values; new trig/dump restarts from chain 0.
REQ-043 Chain 1 asserts done with zero bits; spurious vld on chain 3 during chain 0 -> no word for chain 1, chain 3 bits ignored.
